// File: rtl/pool_writer_pkg.sv
// rtl/pool_writer_pkg.sv - shared parameters, mode encodings and width helper for pool_writer
package pool_writer_pkg;

  localparam int DATA_WIDTH          = 16;
  localparam int NUM_ONE_PIXEL_CYCLE = 6;
  localparam int POOL_ADDR_WIDTH     = 10;
  localparam int COUNT_WRITEBIT      = 3;
  localparam int IMG_W               = 28;
  localparam int IMG_H               = 28;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_MAX    = 2'd1;
  localparam logic [1:0] MODE_AVG    = 2'd2;

  // Index width for a range of v values, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pool_writer_line_buf.sv
// rtl/pool_writer_line_buf.sv - one-row buffer of horizontal pair results for 2x2 pooling
module pool_line_buf #(
  parameter int ENTRIES = 14,
  parameter int WIDTH   = 17,
  parameter int IDX_W   = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // No reset: every entry is written on an even row before the odd row reads it.
  logic [WIDTH-1:0] mem [ENTRIES];

  // Synchronous write of the pair result computed on an even row.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/pool_writer.sv
// rtl/pool_writer.sv - conv pixel writer with bypass, 2x2 max and 2x2 average pooling
module pool_writer #(
  parameter int DATA_WIDTH          = pool_writer_pkg::DATA_WIDTH,
  parameter int NUM_ONE_PIXEL_CYCLE = pool_writer_pkg::NUM_ONE_PIXEL_CYCLE,
  parameter int POOL_ADDR_WIDTH     = pool_writer_pkg::POOL_ADDR_WIDTH,
  parameter int COUNT_WRITEBIT      = pool_writer_pkg::COUNT_WRITEBIT,
  parameter int IMG_W               = pool_writer_pkg::IMG_W,
  parameter int IMG_H               = pool_writer_pkg::IMG_H
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       conv_start,
  input  logic                       conv_done,
  input  logic                       frame_start,
  input  logic [1:0]                 pool_mode,
  output logic [DATA_WIDTH-1:0]      data_a,
  output logic [POOL_ADDR_WIDTH-1:0] address_a_t,
  output logic                       wren_a,
  output logic                       rden_a,
  output logic [DATA_WIDTH-1:0]      data_b,
  output logic [POOL_ADDR_WIDTH-1:0] address_b_t,
  output logic                       wren_b,
  output logic                       rden_b,
  output logic                       frame_done
);

  import pool_writer_pkg::*;

  localparam int COL_W = clog2_min1(IMG_W);
  localparam int ROW_W = clog2_min1(IMG_H);
  localparam int LB_N  = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
  localparam int LB_W  = clog2_min1(LB_N);
  localparam int PW    = DATA_WIDTH + 1;

  logic [COUNT_WRITEBIT-1:0]  cnt;
  logic [COL_W-1:0]           col;
  logic [ROW_W-1:0]           row;
  logic [POOL_ADDR_WIDTH-1:0] addr;
  logic [1:0]                 mode_q;
  logic [DATA_WIDTH-1:0]      hreg;

  logic accept;
  logic take;
  logic is_pool;
  logic is_avg;
  logic col_last;
  logic row_last;
  logic pool_last_blk;
  logic do_write;
  logic done_now;
  logic lb_we;

  logic [LB_W-1:0]        lb_idx;
  logic signed [PW-1:0]   hreg_x;
  logic signed [PW-1:0]   pix_x;
  logic signed [PW-1:0]   pair_val;
  logic signed [PW-1:0]   lb_rdata;
  logic signed [PW-1:0]   max4;
  logic signed [PW:0]     sum4;
  logic signed [PW:0]     avg4;
  logic [DATA_WIDTH-1:0]  pool_out;
  logic [DATA_WIDTH-1:0]  wr_data;

  // A pixel is taken on the last cycle of its window unless conv_done blocks it;
  // a same-cycle frame_start wins and the pixel is dropped.
  assign accept = conv_start & (cnt == COUNT_WRITEBIT'(NUM_ONE_PIXEL_CYCLE - 1)) & ~conv_done;
  assign take   = accept & ~frame_start;

  // Reserved mode 3 falls through to bypass.
  assign is_pool = (mode_q == MODE_MAX) | (mode_q == MODE_AVG);
  assign is_avg  = (mode_q == MODE_AVG);

  assign col_last      = (col == COL_W'(IMG_W - 1));
  assign row_last      = (row == ROW_W'(IMG_H - 1));
  assign pool_last_blk = (col == COL_W'((IMG_W / 2) * 2 - 1)) &
                         (row == ROW_W'((IMG_H / 2) * 2 - 1));

  // Horizontal pair: the held even-column pixel with the current odd-column pixel.
  assign hreg_x   = $signed({hreg[DATA_WIDTH-1], hreg});
  assign pix_x    = $signed({data_in[DATA_WIDTH-1], data_in});
  assign pair_val = is_avg ? (hreg_x + pix_x) : ((pix_x > hreg_x) ? pix_x : hreg_x);

  // Vertical combine of this row's pair with the pair stored from the row above.
  assign max4     = (pair_val > lb_rdata) ? pair_val : lb_rdata;
  assign sum4     = $signed({pair_val[PW-1], pair_val}) + $signed({lb_rdata[PW-1], lb_rdata});
  assign avg4     = sum4 >>> 2;
  assign pool_out = is_avg ? DATA_WIDTH'(avg4) : DATA_WIDTH'(max4);

  // Trailing odd columns/rows never reach an odd/odd position, so they never write.
  assign lb_idx   = LB_W'(col >> 1);
  assign lb_we    = take & is_pool & col[0] & ~row[0];
  assign do_write = take & (~is_pool | (col[0] & row[0]));
  assign done_now = is_pool ? pool_last_blk : (col_last & row_last);
  assign wr_data  = is_pool ? pool_out : data_in;

  pool_line_buf #(
    .ENTRIES (LB_N),
    .WIDTH   (PW),
    .IDX_W   (LB_W)
  ) u_line_buf (
    .clock (clock),
    .we    (lb_we),
    .idx   (lb_idx),
    .wdata (pair_val),
    .rdata (lb_rdata)
  );

  // Window counter: free-runs through each pixel window while conv_start is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (conv_start && (cnt < COUNT_WRITEBIT'(NUM_ONE_PIXEL_CYCLE - 1))) begin
      cnt <= cnt + COUNT_WRITEBIT'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Row-major position of the next incoming pixel, wrapping at the end of the map.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (frame_start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Pooling mode is only sampled at frame_start so a frame never mixes modes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_BYPASS;
    end else if (frame_start) begin
      mode_q <= pool_mode;
    end
  end

  // Hold the even-column pixel until its odd-column partner arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hreg <= '0;
    end else if (take && is_pool && !col[0]) begin
      hreg <= data_in;
    end
  end

  // Port A write, one cycle after the accepting edge; address advances per write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wren_a      <= 1'b0;
      frame_done  <= 1'b0;
      data_a      <= '0;
      address_a_t <= '0;
      addr        <= '0;
    end else begin
      wren_a     <= do_write;
      frame_done <= do_write & done_now;
      if (do_write) begin
        data_a      <= wr_data;
        address_a_t <= addr;
      end
      if (frame_start) begin
        addr <= '0;
      end else if (do_write) begin
        addr <= addr + POOL_ADDR_WIDTH'(1);
      end
    end
  end

  assign rden_a      = 1'b0;
  assign data_b      = '0;
  assign address_b_t = '0;
  assign wren_b      = 1'b0;
  assign rden_b      = 1'b0;

endmodule
